// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One 1-bit full-adder cell is reused over WIDTH clock cycles to form
// {cout,sum} = a + b + cin. The cell works LSB first, and the carry goes
// back into the cell through a register. The operands are held in shift
// registers that move right by one bit on every RUN cycle. Each new sum
// bit enters at the MSB of a sum shift register. On the final bit the
// completed word is copied to the held outputs.

module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit index that is processed on the final RUN edge.
   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_s;
   logic             carry;
   logic [CNTW-1:0]  cnt;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;
   logic [WIDTH-1:0] sum_next;

   // The shared full-adder cell. It operates on the current LSBs and the fed-back carry.
   always_comb begin
      fa_s  = sh_a[0] ^ sh_b[0] ^ carry;
      fa_co = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
   end

   // sum_next is the sum shift register after this cycle's bit has been inserted.
   // last_bit marks the cycle in which the MSB is processed.
   always_comb begin
      sum_next = {fa_s, sh_s[WIDTH-1:1]};
      last_bit = (cnt == LAST);
   end

   // State register. Reset abandons any add that is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Codes that are not used go back to IDLE.
   // A start during RUN or DONE is ignored.
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:    next_state = start ? RUN : IDLE;
         RUN:     next_state = last_bit ? DONE : RUN;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath. Operands are captured on an accepted start, then one bit is added per
   // RUN cycle. The visible result changes only on the edge that enters DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_a  <= '0;
         sh_b  <= '0;
         sh_s  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               sh_s  <= sum_next;
               carry <= fa_co;
               if (last_bit) begin
                  cnt  <= '0;
                  sum  <= sum_next;
                  cout <= fa_co;
               end else begin
                  cnt <= cnt + CNTW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs come only from the state register, so no input reaches them combinationally.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl, WIDTH = 2, 8 and 16 instances.
// A fixed table of vectors and some hand-written sequences exercise the WIDTH=8 instance.
// Random vectors are checked on all three instances against the arithmetic a+b+cin.

module tb_serial_add_ctrl;

   logic        clk;
   logic        rst;

   logic        start2, cin2, busy2, done2, cout2;
   logic [1:0]  a2, b2, sum2;
   logic        start8, cin8, busy8, done8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        start16, cin16, busy16, done16, cout16;
   logic [15:0] a16, b16, sum16;

   int tests;
   int failed;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[8];

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: {cout,sum} is a + b + cin, truncated to w+1 bits.
   function automatic logic [63:0] refAdd(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic c);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return ((av & m) + (bv & m) + {63'd0, c}) & ((m << 1) | 64'd1);
   endfunction

   function automatic logic [63:0] getRes(input int w);
      case (w)
         2:       return {61'd0, cout2, sum2};
         16:      return {47'd0, cout16, sum16};
         default: return {55'd0, cout8, sum8};
      endcase
   endfunction

   function automatic logic getDone(input int w);
      case (w)
         2:       return done2;
         16:      return done16;
         default: return done8;
      endcase
   endfunction

   function automatic logic getBusy(input int w);
      case (w)
         2:       return busy2;
         16:      return busy16;
         default: return busy8;
      endcase
   endfunction

   task automatic setIn(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input logic c, input logic s);
      case (w)
         2:       begin a2 = av[1:0];   b2 = bv[1:0];   cin2 = c;  start2 = s;  end
         16:      begin a16 = av[15:0]; b16 = bv[15:0]; cin16 = c; start16 = s; end
         default: begin a8 = av[7:0];   b8 = bv[7:0];   cin8 = c;  start8 = s;  end
      endcase
   endtask

   // Start one add on the width-w instance. Then check the latency, the result,
   // busy while done is high, and that done lasts a single cycle.
   task automatic applyStimulus(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic c, input logic [63:0] exp, input string tag);
      int lat;
      @(negedge clk);
      setIn(w, av, bv, c, 1'b1);
      @(negedge clk);
      setIn(w, 64'd0, 64'd0, 1'b0, 1'b0);
      lat = 0;
      while (!getDone(w) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         checkOutput({tag, "_timeout"}, 64'(lat), 64'(w));
      end else begin
         checkOutput({tag, "_latency"}, 64'(lat), 64'(w));
         checkOutput({tag, "_result"}, getRes(w), exp);
         checkOutput({tag, "_busy_at_done"}, 64'(getBusy(w)), 64'd1);
         @(negedge clk);
         checkOutput({tag, "_done_one_cycle"}, 64'(getDone(w)), 64'd0);
         checkOutput({tag, "_busy_after"}, 64'(getBusy(w)), 64'd0);
         checkOutput({tag, "_result_held"}, getRes(w), exp);
      end
   endtask

   initial begin
      int n;
      int prev;
      int count;
      int widths[3];
      logic [63:0] ra, rb;
      logic rc;

      tests  = 0;
      failed = 0;
      widths[0] = 2; widths[1] = 8; widths[2] = 16;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

      setIn(2, 0, 0, 0, 0);
      setIn(8, 0, 0, 0, 0);
      setIn(16, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      foreach (widths[i]) begin
         checkOutput($sformatf("reset_busy_w%0d", widths[i]), 64'(getBusy(widths[i])), 64'd0);
         checkOutput($sformatf("reset_done_w%0d", widths[i]), 64'(getDone(widths[i])), 64'd0);
         checkOutput($sformatf("reset_res_w%0d", widths[i]), getRes(widths[i]), 64'd0);
      end
      rst = 1'b0;

      // Table-driven vectors on WIDTH=8.
      foreach (vecs[i]) begin
         applyStimulus(8, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin,
                       {55'd0, vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));
      end

      // A start and operand change in the middle of RUN must be ignored.
      @(negedge clk);
      setIn(8, 64'h12, 64'h34, 1'b0, 1'b1);
      @(negedge clk);
      setIn(8, 64'h12, 64'h34, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      setIn(8, 64'h00, 64'h00, 1'b1, 1'b1);
      @(negedge clk);
      setIn(8, 64'h00, 64'h00, 1'b0, 1'b0);
      count = 0;
      for (int i = 0; i < 20; i++) begin
         if (done8) begin
            count++;
            checkOutput("midrun_result", getRes(8), 64'h046);
         end
         @(negedge clk);
      end
      checkOutput("midrun_done_count", 64'(count), 64'd1);

      // An asynchronous reset in the 4th RUN cycle clears everything at once.
      applyStimulus(8, 64'h5A, 64'h3C, 1'b0, 64'h096, "pre_reset");
      @(negedge clk);
      setIn(8, 64'hF0, 64'h0F, 1'b1, 1'b1);
      @(negedge clk);
      setIn(8, 64'h00, 64'h00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_busy", 64'(busy8), 64'd0);
      checkOutput("async_rst_res", getRes(8), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      count = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) count++;
      end
      checkOutput("no_done_after_rst", 64'(count), 64'd0);
      applyStimulus(8, 64'h12, 64'h34, 1'b0, 64'h046, "after_reset");

      // With start held high, a new add is accepted every WIDTH+2 cycles and the result is held in between.
      @(negedge clk);
      setIn(8, 64'h01, 64'h01, 1'b0, 1'b1);
      prev  = -1;
      count = 0;
      for (n = 0; n < 45; n++) begin
         @(negedge clk);
         if (done8) begin
            count++;
            if (prev >= 0) checkOutput("hold_period", 64'(n - prev), 64'd10);
            prev = n;
            checkOutput("hold_result", getRes(8), 64'h002);
         end else if (prev >= 0) begin
            checkOutput("hold_between", getRes(8), 64'h002);
         end
      end
      checkOutput("hold_enough_dones", 64'(count >= 3), 64'd1);
      setIn(8, 64'h00, 64'h00, 1'b0, 1'b0);
      repeat (15) @(negedge clk);

      // Random vectors on every width, checked against the arithmetic reference.
      foreach (widths[i]) begin
         for (int k = 0; k < 20; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            applyStimulus(widths[i], ra, rb, rc, refAdd(widths[i], ra, rb, rc),
                          $sformatf("rand_w%0d_%0d", widths[i], k));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
